// File: rtl/des_round_iter.sv
// Iterative DES round engine: one Feistel round per clock with an on-the-fly
// key schedule, then the final swap and FP. Fed by pre_processing (PC1 key, IP halves).
module des_round_iter #(
    parameter int N_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    input  logic        dec,
    input  logic [55:0] k,
    input  logic [31:0] l,
    input  logic [31:0] r,
    output logic [63:0] c
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    // Permutation tables use standard DES numbering: bit 1 is the MSB.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    // Indexed by {box, row, column}; S1 first.
    localparam int SBOX [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int n = 0; n < 48; n++) begin
            y[6'(47 - n)] = x[6'(56 - PC2_TAB[n])];
        end
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int n = 0; n < 48; n++) begin
            y[6'(47 - n)] = x[5'(32 - E_TAB[n])];
        end
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int n = 0; n < 32; n++) begin
            y[5'(31 - n)] = x[5'(32 - P_TAB[n])];
        end
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 64; n++) begin
            y[6'(63 - n)] = x[6'(64 - FP_TAB[n])];
        end
        return y;
    endfunction

    // Outer bits of each 6-bit group select the row, inner four the column.
    function automatic logic [31:0] sbox_all(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  chunk;
        logic [8:0]  idx;
        y = '0;
        for (int b = 0; b < 8; b++) begin
            chunk = 6'(x >> (42 - 6 * b));
            idx   = {3'(b), chunk[5], chunk[0], chunk[4:1]};
            y     = {y[27:0], 4'(SBOX[idx])};
        end
        return y;
    endfunction

    function automatic logic [1:0] shift_of(input logic [4:0] idx);
        case (idx)
            5'd1, 5'd2, 5'd9, 5'd16: shift_of = 2'd1;
            default:                 shift_of = 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [55:0] cd_q, cd_d;
    logic [4:0]  i_q, i_d;
    logic        dec_q, dec_d;
    logic [63:0] c_q, c_d;

    logic [1:0]  shift;
    logic [55:0] cd_next;
    logic [47:0] round_key;
    logic [31:0] l_new, r_new;

    // Decryption walks the schedule backwards: key from the current CD, then rotate right.
    always_comb begin
        shift     = shift_of(dec_q ? (5'd17 - i_q) : i_q);
        cd_next   = dec_q ? {rotr28(cd_q[55:28], shift), rotr28(cd_q[27:0], shift)}
                          : {rotl28(cd_q[55:28], shift), rotl28(cd_q[27:0], shift)};
        round_key = dec_q ? perm_pc2(cd_q) : perm_pc2(cd_next);
        l_new     = r_q;
        r_new     = l_q ^ perm_p(sbox_all(perm_e(r_q) ^ round_key));
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cd_d    = cd_q;
        i_d     = i_q;
        dec_d   = dec_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    l_d     = l;
                    r_d     = r;
                    cd_d    = k;
                    dec_d   = dec;
                    i_d     = 5'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                l_d  = l_new;
                r_d  = r_new;
                cd_d = cd_next;
                if (i_q == 5'(N_ROUNDS)) begin
                    c_d     = perm_fp({r_new, l_new});
                    state_d = DONE;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            cd_q    <= '0;
            i_q     <= '0;
            dec_q   <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cd_q    <= cd_d;
            i_q     <= i_d;
            dec_q   <= dec_d;
            c_q     <= c_d;
        end
    end

    assign ack = (state_q == DONE);
    assign c   = c_q;

endmodule
